// File: rtl/signed_add_acc.sv
// Registered signed adder / accumulator behind valid/ready handshakes on both sides.
// Overflow in accumulate mode either wraps or saturates (SAT) and sets a sticky flag.
module signed_add_acc #(
    parameter int unsigned W     = 4,
    parameter int unsigned ACC_W = 8,
    parameter bit          SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             mode,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] z,
    output logic             ovf
);

    localparam int unsigned EW = ACC_W + 2;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] acc;
    logic             accept;
    logic             consume;

    logic [ACC_W-1:0] a_w, b_w, add_sum;
    logic [EW-1:0]    a_e, b_e, acc_e, base_e, acc_sum;
    logic             fits;
    logic [ACC_W-1:0] acc_res;

    logic [ACC_W-1:0] z_d, acc_d;
    logic             out_valid_d, ovf_d;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    // Add mode always fits in ACC_W because ACC_W >= W+1.
    assign a_w     = {{(ACC_W-W){a[W-1]}}, a};
    assign b_w     = {{(ACC_W-W){b[W-1]}}, b};
    assign add_sum = a_w + b_w;

    // Two guard bits keep acc + a + b exact before the range check.
    assign a_e     = {{(EW-W){a[W-1]}}, a};
    assign b_e     = {{(EW-W){b[W-1]}}, b};
    assign acc_e   = {{2{acc[ACC_W-1]}}, acc};
    assign base_e  = clr ? '0 : acc_e;
    assign acc_sum = base_e + a_e + b_e;

    // In range iff the top three bits agree (pure sign extension of ACC_W bits).
    assign fits    = (acc_sum[EW-1:ACC_W-1] == {3{acc_sum[EW-1]}});

    always_comb begin
        acc_res = acc_sum[ACC_W-1:0];
        if (!fits && SAT) begin
            acc_res = acc_sum[EW-1] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        z_d         = z;
        acc_d       = acc;
        out_valid_d = out_valid;
        ovf_d       = ovf;
        if (accept) begin
            out_valid_d = 1'b1;
            if (clr) begin
                acc_d = '0;
                ovf_d = 1'b0;
            end
            if (mode) begin
                z_d   = acc_res;
                acc_d = acc_res;
                ovf_d = (ovf && !clr) || !fits;
            end else begin
                z_d = add_sum;
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z         <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            z         <= z_d;
            acc       <= acc_d;
            out_valid <= out_valid_d;
            ovf       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_signed_add_acc.sv
// Directed bench for signed_add_acc: three instances (5-bit wrap, 6-bit saturate,
// 6-bit wrap) share one stimulus stream and are checked against hand-computed values.
module tb_signed_add_acc;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic [3:0] a, b;
    logic mode, clr, out_ready;

    logic in_ready5, out_valid5, ovf5;
    logic signed [4:0] z5;
    logic in_ready6s, out_valid6s, ovf6s;
    logic signed [5:0] z6s;
    logic in_ready6w, out_valid6w, ovf6w;
    logic signed [5:0] z6w;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    signed_add_acc #(.W(4), .ACC_W(5), .SAT(1'b0)) u_w5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5),
        .a(a), .b(b), .mode(mode), .clr(clr), .out_valid(out_valid5),
        .out_ready(out_ready), .z(z5), .ovf(ovf5)
    );

    signed_add_acc #(.W(4), .ACC_W(6), .SAT(1'b1)) u_s6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6s),
        .a(a), .b(b), .mode(mode), .clr(clr), .out_valid(out_valid6s),
        .out_ready(out_ready), .z(z6s), .ovf(ovf6s)
    );

    signed_add_acc #(.W(4), .ACC_W(6), .SAT(1'b0)) u_w6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6w),
        .a(a), .b(b), .mode(mode), .clr(clr), .out_valid(out_valid6w),
        .out_ready(out_ready), .z(z6w), .ovf(ovf6w)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One accepted transfer with out_ready=1; returns on the negedge after the result lands.
    task automatic xfer(input int xa, input int xb, input logic xm, input logic xc);
        @(negedge clk);
        a        = 4'(xa);
        b        = 4'(xb);
        mode     = xm;
        clr      = xc;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] sa, sb;
        int exp_z;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        mode = 1'b0; clr = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst z", int'(z6s), 0);
        check("rst out_valid", int'(out_valid6s), 0);
        check("rst ovf", int'(ovf6s), 0);
        check("rst in_ready", int'(in_ready6s), 1);
        rst_n = 1'b1;

        // Add-mode sweep, back to back, 5-bit wrap instance.
        sa = 4'd0; sb = 4'd7; exp_z = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("s1 z", int'(z5), exp_z);
                check("s1 out_valid", int'(out_valid5), 1);
            end
            a = sa; b = sb; mode = 1'b0; clr = 1'b0; in_valid = 1'b1;
            exp_z = int'($signed(sa)) + int'($signed(sb));
            sa = sa + 4'd1;
            sb = sb + 4'd1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("s1 z last", int'(z5), exp_z);
        check("s1 ovf", int'(ovf5), 0);

        // Accumulate to overflow: saturate vs wrap.
        xfer(7, 7, 1'b1, 1'b1);
        check("s2 z1", int'(z6s), 14);  check("s3 z1", int'(z6w), 14);
        check("s2 ovf1", int'(ovf6s), 0);
        xfer(7, 7, 1'b1, 1'b0);
        check("s2 z2", int'(z6s), 28);  check("s3 z2", int'(z6w), 28);
        check("s2 ovf2", int'(ovf6s), 0);
        xfer(7, 7, 1'b1, 1'b0);
        check("s2 z3", int'(z6s), 31);  check("s3 z3", int'(z6w), -22);
        check("s2 ovf3", int'(ovf6s), 1); check("s3 ovf3", int'(ovf6w), 1);
        xfer(-8, -8, 1'b1, 1'b0);
        check("s2 z4", int'(z6s), 15);
        xfer(-8, -8, 1'b1, 1'b0);
        check("s2 z5", int'(z6s), -1);
        xfer(-8, -8, 1'b1, 1'b0);
        check("s2 z6", int'(z6s), -17);
        xfer(-8, -8, 1'b1, 1'b0);
        check("s2 z7", int'(z6s), -32);
        check("s2 ovf sticky", int'(ovf6s), 1);
        xfer(1, 2, 1'b1, 1'b1);
        check("s3 clr z", int'(z6w), 3);  check("s3 clr ovf", int'(ovf6w), 0);
        check("s2 clr z", int'(z6s), 3);  check("s2 clr ovf", int'(ovf6s), 0);

        // Backpressure: result held, input blocked, then full-throughput release.
        @(negedge clk);
        out_ready = 1'b0;
        a = 4'd3; b = 4'd4; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s4 hold z", int'(z6s), 7);
            check("s4 hold out_valid", int'(out_valid6s), 1);
            check("s4 in_ready", int'(in_ready6s), 0);
            a = 4'(5 + i); b = 4'(2 - i);
        end
        out_ready = 1'b1;
        a = 4'd1; b = 4'd1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("s4 release z", int'(z6s), 2);
        check("s4 release out_valid", int'(out_valid6s), 1);
        @(negedge clk);
        check("s4 drain out_valid", int'(out_valid6s), 0);
        check("s4 drain z", int'(z6s), 2);

        // Asynchronous reset between edges with a result pending.
        xfer(7, 7, 1'b1, 1'b1);
        xfer(7, 7, 1'b1, 1'b0);
        xfer(7, 7, 1'b1, 1'b0);
        xfer(-8, -3, 1'b1, 1'b0);
        check("s5 pre z", int'(z6s), 20);
        check("s5 pre ovf", int'(ovf6s), 1);
        rst_n = 1'b0;
        #1;
        check("s5 rst z", int'(z6s), 0);
        check("s5 rst out_valid", int'(out_valid6s), 0);
        check("s5 rst ovf", int'(ovf6s), 0);
        #1 rst_n = 1'b1;
        xfer(1, 1, 1'b1, 1'b0);
        check("s5 post z", int'(z6s), 2);

        // Mode interleave: add leaves acc untouched.
        xfer(5, 5, 1'b1, 1'b1);
        check("s6 acc10", int'(z6s), 10);
        xfer(5, 5, 1'b0, 1'b0);
        check("s6 add z", int'(z6s), 10);
        xfer(1, 0, 1'b1, 1'b0);
        check("s6 acc z", int'(z6s), 11);
        check("s6 ovf", int'(ovf6s), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
